// File: rtl/mouse_device_sm.sv
// -----------------------------------------------------------------------------
// mouse_device_sm
//
// Byte-level PS/2 mouse device emulator. Sits behind a device-side PS/2 byte
// transmitter/receiver pair and answers host commands: reset/BAT (FF), enable
// (F4), disable (F5), set defaults (F6), set sample rate (F3 + argument), get
// device ID (F2), and the IntelliMouse 200/100/80 rate-sequence unlock. While
// streaming is enabled, it sends 3-byte packets, or 4-byte packets in
// IntelliMouse mode, built from a movement source.
//
// Ports:
//   CLK, RESET          clock; synchronous active-high reset
//   RX_READ_ENABLE  o   high while a host byte will be accepted
//   RX_BYTE_READY   i   one-cycle pulse, RX_BYTE/RX_ERROR valid
//   RX_BYTE         i   received host byte
//   RX_ERROR        i   00 = ok, nonzero = parity/framing error
//   TX_SEND_BYTE    o   one-cycle pulse, start sending TX_BYTE
//   TX_BYTE         o   byte being sent, held until TX_BYTE_SENT
//   TX_BYTE_SENT    i   one-cycle pulse, byte fully sent
//   MOVE_VALID      i   movement sample available
//   MOVE_STATUS     i   buttons/sign/overflow (bit3 forced to 1 on output)
//   MOVE_DX/DY/DZ   i   movement deltas
//   MOVE_ACCEPT     o   one-cycle pulse when the sample is latched
//   STREAMING       o   data reporting enabled
//   INTELLI_MODE    o   device ID 03, 4-byte packets
//   SAMPLE_RATE     o   last accepted sample rate
// -----------------------------------------------------------------------------
module mouse_device_sm #(
  parameter int unsigned BAT_DELAY    = 1000,
  parameter logic [7:0]  DEFAULT_RATE = 8'h64
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       RX_READ_ENABLE,
  input  logic       RX_BYTE_READY,
  input  logic [7:0] RX_BYTE,
  input  logic [1:0] RX_ERROR,
  output logic       TX_SEND_BYTE,
  output logic [7:0] TX_BYTE,
  input  logic       TX_BYTE_SENT,
  input  logic       MOVE_VALID,
  input  logic [7:0] MOVE_STATUS,
  input  logic [7:0] MOVE_DX,
  input  logic [7:0] MOVE_DY,
  input  logic [7:0] MOVE_DZ,
  output logic       MOVE_ACCEPT,
  output logic       STREAMING,
  output logic       INTELLI_MODE,
  output logic [7:0] SAMPLE_RATE
);

  typedef enum logic [2:0] {
    ST_BAT_WAIT,
    ST_IDLE,
    ST_ARG_WAIT,
    ST_SEND,
    ST_WAIT_SENT
  } state_e;

  localparam logic [31:0] BAT_LAST    = 32'(BAT_DELAY - 1);
  localparam logic [23:0] UNLOCK_SEQ  = 24'hC8_64_50;

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;        // where to go once the response drains
  logic [31:0]      cnt_q, cnt_d;        // BAT delay counter
  logic [2:0][7:0]  q_q, q_d;            // response queue, entry 0 is the head
  logic [1:0]       qcnt_q, qcnt_d;
  logic [3:0][7:0]  pkt_q, pkt_d;        // latched movement packet, entry 0 first
  logic [1:0]       pkt_idx_q, pkt_idx_d;
  logic [1:0]       pkt_last_q, pkt_last_d;
  logic             pkt_act_q, pkt_act_d;
  logic [15:0]      hist_q, hist_d;      // last two set-rate arguments, [7:0] newest
  logic             stream_q, stream_d;
  logic             intelli_q, intelli_d;
  logic [7:0]       rate_q, rate_d;
  logic             rx_en_q, rx_en_d;
  logic             tx_send_q, tx_send_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             move_acc_q, move_acc_d;

  logic             rx_take;
  logic [23:0]      new_hist;

  assign rx_take  = RX_BYTE_READY && rx_en_q;
  assign new_hist = {hist_q, RX_BYTE};

  always_comb begin
    // NOTE: every _d signal takes its hold value first, so no branch of the
    // case below can leave one unassigned and infer a latch.
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    qcnt_d     = qcnt_q;
    pkt_d      = pkt_q;
    pkt_idx_d  = pkt_idx_q;
    pkt_last_d = pkt_last_q;
    pkt_act_d  = pkt_act_q;
    hist_d     = hist_q;
    stream_d   = stream_q;
    intelli_d  = intelli_q;
    rate_d     = rate_q;
    tx_byte_d  = tx_byte_q;
    tx_send_d  = 1'b0;
    move_acc_d = 1'b0;

    case (state_q)
      ST_BAT_WAIT: begin
        if (cnt_q == BAT_LAST) begin
          q_d     = {8'h00, 8'h00, 8'hAA};
          qcnt_d  = 2'd2;
          ret_d   = ST_IDLE;
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_IDLE, ST_ARG_WAIT: begin
        if (rx_take) begin
          // Most outcomes are a single FA followed by IDLE; branches override.
          state_d = ST_SEND;
          q_d     = {8'h00, 8'h00, 8'hFA};
          qcnt_d  = 2'd1;
          ret_d   = ST_IDLE;
          if (RX_ERROR != 2'b00) begin
            q_d[0] = 8'hFE;
            ret_d  = state_q;
          end else if (RX_BYTE == 8'hFF) begin
            stream_d  = 1'b0;
            intelli_d = 1'b0;
            rate_d    = DEFAULT_RATE;
            hist_d    = '0;
            cnt_d     = '0;
            ret_d     = ST_BAT_WAIT;
          end else if (state_q == ST_ARG_WAIT) begin
            rate_d = RX_BYTE;
            hist_d = new_hist[15:0];
            if (new_hist == UNLOCK_SEQ) intelli_d = 1'b1;
          end else begin
            case (RX_BYTE)
              8'hF4: stream_d = 1'b1;
              8'hF5: stream_d = 1'b0;
              8'hF6: begin
                stream_d = 1'b0;
                rate_d   = DEFAULT_RATE;
              end
              8'hF3: ret_d = ST_ARG_WAIT;
              8'hF2: begin
                q_d[1] = intelli_q ? 8'h03 : 8'h00;
                qcnt_d = 2'd2;
              end
              default: q_d[0] = 8'hFE;
            endcase
          end
        end else if ((state_q == ST_IDLE) && stream_q && MOVE_VALID && !RX_BYTE_READY) begin
          // Packet length is fixed here, so a mode change cannot alter a
          // packet already under way.
          pkt_d      = {MOVE_DZ, MOVE_DY, MOVE_DX, MOVE_STATUS | 8'h08};
          pkt_last_d = intelli_q ? 2'd3 : 2'd2;
          pkt_idx_d  = 2'd0;
          pkt_act_d  = 1'b1;
          move_acc_d = 1'b1;
          ret_d      = ST_IDLE;
          state_d    = ST_SEND;
        end
      end

      ST_SEND: begin
        tx_send_d = 1'b1;
        tx_byte_d = pkt_act_q ? pkt_q[pkt_idx_q] : q_q[0];
        state_d   = ST_WAIT_SENT;
      end

      ST_WAIT_SENT: begin
        if (TX_BYTE_SENT) begin
          if (pkt_act_q) begin
            if (pkt_idx_q == pkt_last_q) begin
              pkt_act_d = 1'b0;
              state_d   = ret_q;
            end else begin
              pkt_idx_d = pkt_idx_q + 2'd1;
              state_d   = ST_SEND;
            end
          end else begin
            q_d     = {8'h00, q_q[2], q_q[1]};
            qcnt_d  = qcnt_q - 2'd1;
            state_d = (qcnt_q == 2'd1) ? ret_q : ST_SEND;
          end
        end
      end

      default: begin
        state_d = ST_BAT_WAIT;
        cnt_d   = '0;
      end
    endcase

    rx_en_d = (state_d == ST_IDLE) || (state_d == ST_ARG_WAIT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values of the previous cycle regardless of order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_BAT_WAIT;
      ret_q      <= ST_IDLE;
      cnt_q      <= '0;
      // NOTE: the queue and packet storage are cleared as well, so TX_BYTE can
      // never expose an undefined byte after reset.
      q_q        <= '0;
      qcnt_q     <= '0;
      pkt_q      <= '0;
      pkt_idx_q  <= '0;
      pkt_last_q <= '0;
      pkt_act_q  <= 1'b0;
      hist_q     <= '0;
      stream_q   <= 1'b0;
      intelli_q  <= 1'b0;
      rate_q     <= DEFAULT_RATE;
      rx_en_q    <= 1'b0;
      tx_send_q  <= 1'b0;
      tx_byte_q  <= 8'h00;
      move_acc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      qcnt_q     <= qcnt_d;
      pkt_q      <= pkt_d;
      pkt_idx_q  <= pkt_idx_d;
      pkt_last_q <= pkt_last_d;
      pkt_act_q  <= pkt_act_d;
      hist_q     <= hist_d;
      stream_q   <= stream_d;
      intelli_q  <= intelli_d;
      rate_q     <= rate_d;
      rx_en_q    <= rx_en_d;
      tx_send_q  <= tx_send_d;
      tx_byte_q  <= tx_byte_d;
      move_acc_q <= move_acc_d;
    end
  end

  assign RX_READ_ENABLE = rx_en_q;
  assign TX_SEND_BYTE   = tx_send_q;
  assign TX_BYTE        = tx_byte_q;
  assign MOVE_ACCEPT    = move_acc_q;
  assign STREAMING      = stream_q;
  assign INTELLI_MODE   = intelli_q;
  assign SAMPLE_RATE    = rate_q;

endmodule

// File: tb/tb_mouse_device_sm.sv
// -----------------------------------------------------------------------------
// tb_mouse_device_sm
//
// Drives mouse_device_sm as a host would: host bytes are offered only while
// RX_READ_ENABLE is high, and every TX_SEND_BYTE is answered by TX_BYTE_SENT
// 20 cycles later. A table of command/movement records holds hand-computed
// response bytes and flag values; reset, the command-during-packet case and
// reset mid-transmission are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mouse_device_sm;

  localparam int BD      = 50;
  localparam int LIMIT   = 3000;
  localparam int SENT_DLY = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_read_enable;
  logic       rx_byte_ready;
  logic [7:0] rx_byte;
  logic [1:0] rx_error;
  logic       tx_send_byte;
  logic [7:0] tx_byte;
  logic       tx_byte_sent;
  logic       move_valid;
  logic [7:0] move_status, move_dx, move_dy, move_dz;
  logic       move_accept;
  logic       streaming;
  logic       intelli_mode;
  logic [7:0] sample_rate;

  mouse_device_sm #(.BAT_DELAY(BD), .DEFAULT_RATE(8'h64)) dut (
    .CLK            (clk),
    .RESET          (reset),
    .RX_READ_ENABLE (rx_read_enable),
    .RX_BYTE_READY  (rx_byte_ready),
    .RX_BYTE        (rx_byte),
    .RX_ERROR       (rx_error),
    .TX_SEND_BYTE   (tx_send_byte),
    .TX_BYTE        (tx_byte),
    .TX_BYTE_SENT   (tx_byte_sent),
    .MOVE_VALID     (move_valid),
    .MOVE_STATUS    (move_status),
    .MOVE_DX        (move_dx),
    .MOVE_DY        (move_dy),
    .MOVE_DZ        (move_dz),
    .MOVE_ACCEPT    (move_accept),
    .STREAMING      (streaming),
    .INTELLI_MODE   (intelli_mode),
    .SAMPLE_RATE    (sample_rate)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] txlog[$];
  int         acc_cnt = 0;
  logic       busy    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model: log each byte, answer with TX_BYTE_SENT after SENT_DLY
  // cycles, and flag a new send issued before the previous one completed.
  initial begin
    int dly;
    dly = 0;
    tx_byte_sent = 1'b0;
    forever begin
      @(negedge clk);
      tx_byte_sent = 1'b0;
      if (move_accept) acc_cnt++;
      if (tx_send_byte) begin
        check("tx_no_overlap", {31'd0, busy}, 32'd0);
        txlog.push_back(tx_byte);
        busy = 1'b1;
        dly  = SENT_DLY;
      end else if (busy) begin
        dly--;
        if (dly == 0) begin
          tx_byte_sent = 1'b1;
          busy         = 1'b0;
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_rx_en(input string name);
    int n;
    n = 0;
    while (!rx_read_enable && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!rx_read_enable) check({name, "_rx_en_timeout"}, {31'd0, rx_read_enable}, 32'd1);
  endtask

  task automatic wait_log(input string name, input int n);
    int k;
    k = 0;
    while (txlog.size() < n && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    if (txlog.size() < n) check({name, "_tx_count_timeout"}, txlog.size(), n);
  endtask

  task automatic send_host(input logic [7:0] b, input logic [1:0] err);
    wait_rx_en("host");
    rx_byte       = b;
    rx_error      = err;
    rx_byte_ready = 1'b1;
    @(negedge clk);
    rx_byte_ready = 1'b0;
    rx_error      = 2'b00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_send"},  {31'd0, tx_send_byte},   32'd0);
    check({tag, "_tx_byte"},  {24'd0, tx_byte},        32'h00);
    check({tag, "_rx_en"},    {31'd0, rx_read_enable}, 32'd0);
    check({tag, "_move_acc"}, {31'd0, move_accept},    32'd0);
    check({tag, "_stream"},   {31'd0, streaming},      32'd0);
    check({tag, "_intelli"},  {31'd0, intelli_mode},   32'd0);
    check({tag, "_rate"},     {24'd0, sample_rate},    32'h64);
  endtask

  // Count cycles from reset release to the first send; expect the AA,00 pair.
  task automatic check_bat(input string tag);
    int cyc;
    cyc = 0;
    while (!tx_send_byte && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_bat_not_early"}, {31'd0, cyc >= BD},     32'd1);
    check({tag, "_bat_not_late"},  {31'd0, cyc <= BD + 2}, 32'd1);
    wait_log(tag, 2);
    if (txlog.size() >= 2) begin
      check({tag, "_bat_aa"}, {24'd0, txlog[0]}, 32'hAA);
      check({tag, "_bat_00"}, {24'd0, txlog[1]}, 32'h00);
    end
    wait_rx_en(tag);
    check({tag, "_bat_stream"}, {31'd0, streaming},   32'd0);
    check({tag, "_bat_rate"},   {24'd0, sample_rate}, 32'h64);
  endtask

  typedef struct {
    logic        is_move;
    logic [1:0]  err;
    logic [31:0] stim;    // command in [31:24], or {status, dx, dy, dz}
    int          nresp;
    logic [31:0] resp;    // expected bytes, first in [31:24]
    logic        exp_stream;
    logic        exp_intelli;
    logic [7:0]  exp_rate;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input logic mv, input logic [1:0] er, input logic [31:0] st,
                               input int n, input logic [31:0] rs,
                               input logic s, input logic i, input logic [7:0] r);
    vec_t v;
    v.is_move = mv; v.err = er; v.stim = st; v.nresp = n; v.resp = rs;
    v.exp_stream = s; v.exp_intelli = i; v.exp_rate = r;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    string tag;
    int    acc0;
    int    k;
    tag  = $sformatf("v%0d", idx);
    txlog.delete();
    acc0 = acc_cnt;
    if (v.is_move) begin
      wait_rx_en(tag);
      move_status = v.stim[31:24];
      move_dx     = v.stim[23:16];
      move_dy     = v.stim[15:8];
      move_dz     = v.stim[7:0];
      move_valid  = 1'b1;
      k = 0;
      while (!move_accept && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (!move_accept) check({tag, "_accept_timeout"}, {31'd0, move_accept}, 32'd1);
      move_valid  = 1'b0;
      move_status = 8'hEE; move_dx = 8'hEE; move_dy = 8'hEE; move_dz = 8'hEE;
    end else begin
      send_host(v.stim[31:24], v.err);
    end
    wait_log(tag, v.nresp);
    for (int b = 0; b < v.nresp; b++) begin
      if (b < txlog.size())
        check($sformatf("%s_byte%0d", tag, b), {24'd0, txlog[b]}, {24'd0, v.resp[31 - 8*b -: 8]});
    end
    wait_rx_en(tag);
    check({tag, "_nbytes"},  txlog.size(),             v.nresp);
    check({tag, "_accepts"}, acc_cnt - acc0,           v.is_move ? 1 : 0);
    check({tag, "_stream"},  {31'd0, streaming},       {31'd0, v.exp_stream});
    check({tag, "_intelli"}, {31'd0, intelli_mode},    {31'd0, v.exp_intelli});
    check({tag, "_rate"},    {24'd0, sample_rate},     {24'd0, v.exp_rate});
  endtask

  initial begin
    logic [7:0] exp_a [5];
    int         acc0;
    int         k;

    reset = 1'b1;
    rx_byte_ready = 1'b0; rx_byte = 8'h00; rx_error = 2'b00;
    move_valid = 1'b0; move_status = 8'h00; move_dx = 8'h00; move_dy = 8'h00; move_dz = 8'h00;

    //            move err  stimulus       n  expected bytes  strm intl rate
    tbl.push_back(mkv(0, 2'd0, 32'hFF000000, 3, 32'hFAAA0000, 0, 0, 8'h64));
    tbl.push_back(mkv(0, 2'd0, 32'hF2000000, 2, 32'hFA000000, 0, 0, 8'h64));
    tbl.push_back(mkv(0, 2'd0, 32'hF3000000, 1, 32'hFA000000, 0, 0, 8'h64));
    tbl.push_back(mkv(0, 2'd0, 32'h28000000, 1, 32'hFA000000, 0, 0, 8'h28));
    tbl.push_back(mkv(0, 2'd0, 32'hF3000000, 1, 32'hFA000000, 0, 0, 8'h28));
    tbl.push_back(mkv(0, 2'd0, 32'hFF000000, 3, 32'hFAAA0000, 0, 0, 8'h64)); // FF as argument
    tbl.push_back(mkv(0, 2'd0, 32'hF4000000, 1, 32'hFA000000, 1, 0, 8'h64));
    tbl.push_back(mkv(1, 2'd0, 32'h0105FB77, 3, 32'h0905FB00, 1, 0, 8'h64)); // 3-byte packet
    tbl.push_back(mkv(0, 2'd0, 32'hF3000000, 1, 32'hFA000000, 1, 0, 8'h64)); // C8,50,64: no unlock
    tbl.push_back(mkv(0, 2'd0, 32'hC8000000, 1, 32'hFA000000, 1, 0, 8'hC8));
    tbl.push_back(mkv(0, 2'd0, 32'hF3000000, 1, 32'hFA000000, 1, 0, 8'hC8));
    tbl.push_back(mkv(0, 2'd0, 32'h50000000, 1, 32'hFA000000, 1, 0, 8'h50));
    tbl.push_back(mkv(0, 2'd0, 32'hF3000000, 1, 32'hFA000000, 1, 0, 8'h50));
    tbl.push_back(mkv(0, 2'd0, 32'h64000000, 1, 32'hFA000000, 1, 0, 8'h64));
    tbl.push_back(mkv(0, 2'd0, 32'hF2000000, 2, 32'hFA000000, 1, 0, 8'h64));
    tbl.push_back(mkv(0, 2'd0, 32'hF3000000, 1, 32'hFA000000, 1, 0, 8'h64)); // C8,64,50: unlock
    tbl.push_back(mkv(0, 2'd0, 32'hC8000000, 1, 32'hFA000000, 1, 0, 8'hC8));
    tbl.push_back(mkv(0, 2'd0, 32'hF3000000, 1, 32'hFA000000, 1, 0, 8'hC8));
    tbl.push_back(mkv(0, 2'd0, 32'h64000000, 1, 32'hFA000000, 1, 0, 8'h64));
    tbl.push_back(mkv(0, 2'd0, 32'hF3000000, 1, 32'hFA000000, 1, 0, 8'h64));
    tbl.push_back(mkv(0, 2'd0, 32'h50000000, 1, 32'hFA000000, 1, 1, 8'h50));
    tbl.push_back(mkv(0, 2'd0, 32'hF2000000, 2, 32'hFA030000, 1, 1, 8'h50));
    tbl.push_back(mkv(1, 2'd0, 32'h0105FB01, 4, 32'h0905FB01, 1, 1, 8'h50)); // 4-byte packet
    tbl.push_back(mkv(1, 2'd0, 32'h0A807FFF, 4, 32'h0A807FFF, 1, 1, 8'h50));
    tbl.push_back(mkv(0, 2'd0, 32'hF6000000, 1, 32'hFA000000, 0, 1, 8'h64));
    tbl.push_back(mkv(0, 2'd0, 32'hF4000000, 1, 32'hFA000000, 1, 1, 8'h64));
    tbl.push_back(mkv(0, 2'd1, 32'hF5000000, 1, 32'hFE000000, 1, 1, 8'h64)); // error byte ignored
    tbl.push_back(mkv(0, 2'd0, 32'hE9000000, 1, 32'hFE000000, 1, 1, 8'h64)); // unknown command
    tbl.push_back(mkv(0, 2'd0, 32'hF3000000, 1, 32'hFA000000, 1, 1, 8'h64));
    tbl.push_back(mkv(0, 2'd2, 32'h32000000, 1, 32'hFE000000, 1, 1, 8'h64)); // stays in ARG_WAIT
    tbl.push_back(mkv(0, 2'd0, 32'h32000000, 1, 32'hFA000000, 1, 1, 8'h32));

    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    reset = 1'b0;
    check_bat("boot");

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Host F5 offered during a 4-byte packet: the packet completes first.
    txlog.delete();
    acc0 = acc_cnt;
    move_status = 8'h01; move_dx = 8'h05; move_dy = 8'hFB; move_dz = 8'h01;
    move_valid  = 1'b1;
    k = 0;
    while (!move_accept && k < 200) begin
      @(negedge clk);
      k++;
    end
    move_valid = 1'b0;
    check("pkt_rx_en_low", {31'd0, rx_read_enable}, 32'd0);
    // A stray byte pulse while reads are disabled must be ignored.
    rx_byte = 8'hE9; rx_byte_ready = 1'b1;
    @(negedge clk);
    rx_byte_ready = 1'b0;
    send_host(8'hF5, 2'b00);
    exp_a[0] = 8'h09; exp_a[1] = 8'h05; exp_a[2] = 8'hFB; exp_a[3] = 8'h01; exp_a[4] = 8'hFA;
    wait_log("pkt_f5", 5);
    for (int b = 0; b < 5; b++) begin
      if (b < txlog.size()) check($sformatf("pkt_f5_byte%0d", b), {24'd0, txlog[b]}, {24'd0, exp_a[b]});
    end
    wait_rx_en("pkt_f5");
    check("pkt_f5_stream", {31'd0, streaming}, 32'd0);
    move_valid = 1'b1;
    repeat (100) @(negedge clk);
    move_valid = 1'b0;
    check("pkt_f5_accepts", acc_cnt - acc0, 32'd1);
    check("pkt_f5_nbytes",  txlog.size(),   32'd5);

    // Reset between TX_SEND_BYTE and TX_BYTE_SENT.
    send_host(8'hF4, 2'b00);
    wait_rx_en("pre_rst");
    send_host(8'hF2, 2'b00);
    k = 0;
    while (!tx_send_byte && k < 200) begin
      @(negedge clk);
      k++;
    end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst1");
    txlog.delete();
    reset = 1'b0;
    check_bat("rst1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
